// File: rtl/ddr3_cmd_queue_pkg.sv
// Shared types for the CPU-side DDR3 request queue: command encoding,
// address-field widths and the queued request record.
package ddr3_cmd_queue_pkg;

    localparam int ROW_W  = 15;
    localparam int BA_W   = 3;
    localparam int COL_W  = 10;
    localparam int DATA_W = 64;
    localparam int DM_W   = 8;
    localparam int ADDR_W = 32;

    typedef enum logic {
        CMD_READ  = 1'b0,
        CMD_WRITE = 1'b1
    } cmd_e;

    typedef struct packed {
        cmd_e              cmd;
        logic [BA_W-1:0]   ba;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] wr_data;
        logic [DM_W-1:0]   dm;
    } ddr3_req_t;

endpackage

// File: rtl/ddr3_cmd_queue_if.sv
// CPU request / FSM head-of-queue bundle around ddr3_cmd_queue.
// master = CPU + command FSM side, slave = the queue itself.
interface ddr3_cmd_queue_if #(parameter int DEPTH = 8);
    import ddr3_cmd_queue_pkg::*;

    logic                      addr_valid;
    logic                      cs;
    logic                      cmd;
    logic [ADDR_W-1:0]         addr;
    logic [DATA_W-1:0]         wr_data;
    logic [DM_W-1:0]           dm;
    logic                      cpu_rdy;
    logic                      q_valid;
    logic                      q_cmd;
    logic [BA_W-1:0]           q_ba;
    logic [ROW_W-1:0]          q_row;
    logic [COL_W-1:0]          q_col;
    logic [DATA_W-1:0]         q_wr_data;
    logic [DM_W-1:0]           q_dm;
    logic                      q_row_hit;
    logic                      q_accept;
    logic                      pre_all;
    logic [$clog2(DEPTH):0]    count;
    logic                      align_err;

    modport master (
        output addr_valid, cs, cmd, addr, wr_data, dm, q_accept, pre_all,
        input  cpu_rdy, q_valid, q_cmd, q_ba, q_row, q_col, q_wr_data, q_dm,
               q_row_hit, count, align_err
    );

    modport slave (
        input  addr_valid, cs, cmd, addr, wr_data, dm, q_accept, pre_all,
        output cpu_rdy, q_valid, q_cmd, q_ba, q_row, q_col, q_wr_data, q_dm,
               q_row_hit, count, align_err
    );

endinterface

// File: rtl/ddr3_cmd_queue_fifo.sv
// Generic synchronous FIFO, DEPTH (power of 2) entries of type T.
// Latency: 1 cycle push-to-visible, no fall-through. Backpressure: push_rdy low when full.
// Push and pop may coincide whenever push_rdy is high; when full only the pop happens.
module ddr3_cmd_queue_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0],
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  T              push_dat,
    output logic          push_rdy,
    output logic          pop_vld,
    input  logic          pop_rdy,
    output T              pop_dat,
    output logic [CW-1:0] count
);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign push_rdy = (count != CW'(DEPTH));
    assign pop_vld  = (count != '0);
    assign push     = push_vld & push_rdy;
    assign pop      = pop_vld & pop_rdy;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    // Power-of-2 depth: pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/ddr3_cmd_queue.sv
// CPU request queue feeding the DDR3 command FSM: decodes bank/row/col at push, tracks open rows.
// Latency: 1 cycle push-to-head, head fields combinational. Backpressure: cpu_rdy low when full.
module ddr3_cmd_queue #(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    ddr3_cmd_queue_if.slave   q
);
    import ddr3_cmd_queue_pkg::*;

    localparam int NB = 2 ** BA_W;

    ddr3_req_t        push_req;
    ddr3_req_t        head;
    ddr3_req_t        head_q;
    logic             head_vld;
    logic             fifo_rdy;
    logic             push;
    logic             pop;
    logic             unused_addr;
    logic [NB-1:0]    open_vld;
    logic [ROW_W-1:0] open_row [NB];

    // Byte address -> {row, bank, burst-aligned column}; low 3 bits are dropped.
    assign push_req.cmd     = cmd_e'(q.cmd);
    assign push_req.ba      = q.addr[12:10];
    assign push_req.row     = q.addr[27:13];
    assign push_req.col     = {q.addr[9:3], 3'b000};
    assign push_req.wr_data = q.wr_data;
    assign push_req.dm      = q.dm;
    assign unused_addr      = ^q.addr[31:28];

    ddr3_cmd_queue_fifo #(
        .DEPTH (DEPTH),
        .T     (ddr3_req_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (q.addr_valid & q.cs),
        .push_dat (push_req),
        .push_rdy (fifo_rdy),
        .pop_vld  (head_vld),
        .pop_rdy  (q.q_accept),
        .pop_dat  (head),
        .count    (q.count)
    );

    assign push   = q.addr_valid & q.cs & fifo_rdy;
    assign pop    = head_vld & q.q_accept;
    assign head_q = head_vld ? head : '0;

    assign q.cpu_rdy   = fifo_rdy;
    assign q.q_valid   = head_vld;
    assign q.q_cmd     = head_q.cmd;
    assign q.q_ba      = head_q.ba;
    assign q.q_row     = head_q.row;
    assign q.q_col     = head_q.col;
    assign q.q_wr_data = head_q.wr_data;
    assign q.q_dm      = head_q.dm;
    assign q.q_row_hit = head_vld & open_vld[head.ba] & (open_row[head.ba] == head.row);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q.align_err <= 1'b0;
        end else if (push && (q.addr[2:0] != 3'b000)) begin
            q.align_err <= 1'b1;
        end
    end

    // PRE_ALL clears first; a same-cycle pop then re-opens its bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_vld <= '0;
            for (int i = 0; i < NB; i++) open_row[i] <= '0;
        end else begin
            if (q.pre_all) open_vld <= '0;
            if (pop) begin
                open_vld[head.ba] <= 1'b1;
                open_row[head.ba] <= head.row;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_cmd_queue.sv
// Directed bench for ddr3_cmd_queue: decode, fill/backpressure, push+pop, row hits,
// misalignment and asynchronous reset with entries queued.
module tb_ddr3_cmd_queue;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    ddr3_cmd_queue_if #(.DEPTH(8)) bus ();

    ddr3_cmd_queue #(.DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input logic cmd, input logic [31:0] addr);
        bus.addr_valid = 1'b1;
        bus.cmd        = cmd;
        bus.addr       = addr;
        tick();
        bus.addr_valid = 1'b0;
    endtask

    task automatic pop_one();
        bus.q_accept = 1'b1;
        tick();
        bus.q_accept = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst            = 1'b1;
        bus.addr_valid = 1'b0;
        bus.cs         = 1'b1;
        bus.cmd        = 1'b0;
        bus.addr       = '0;
        bus.wr_data    = '0;
        bus.dm         = '0;
        bus.q_accept   = 1'b0;
        bus.pre_all    = 1'b0;
        tick();
        check("rst_cpu_rdy", bus.cpu_rdy, 1);
        check("rst_q_valid", bus.q_valid, 0);
        check("rst_count", bus.count, 0);
        check("rst_align", bus.align_err, 0);
        rst = 1'b0;
        tick();

        // Decode of a write: 0x0012_3458 -> row 0x91, bank 5, col 0x058
        bus.wr_data = 64'hDEAD_BEEF_0123_4567;
        bus.dm      = 8'h0F;
        check("pre_push_valid", bus.q_valid, 0);
        push_one(1'b1, 32'h0012_3458);
        check("dec_valid", bus.q_valid, 1);
        check("dec_cmd", bus.q_cmd, 1);
        check("dec_col", bus.q_col, 10'h058);
        check("dec_ba", bus.q_ba, 3'h5);
        check("dec_row", bus.q_row, 15'h091);
        check("dec_dm", bus.q_dm, 8'h0F);
        check("dec_wdata", bus.q_wr_data, 64'hDEAD_BEEF_0123_4567);
        check("dec_align", bus.align_err, 0);
        check("dec_count", bus.count, 1);
        pop_one();
        check("dec_pop_count", bus.count, 0);
        check("dec_pop_valid", bus.q_valid, 0);

        // Fill with 9 reads; entry i is row i+2, col i*8
        bus.dm = 8'h00;
        bus.cmd = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.addr_valid = 1'b1;
            bus.addr       = ((i + 2) << 13) | (i << 3);
            tick();
        end
        check("fill_count", bus.count, 8);
        check("fill_rdy", bus.cpu_rdy, 0);
        check("fill_head_row", bus.q_row, 2);
        bus.q_accept = 1'b1;
        tick();
        bus.q_accept = 1'b0;
        check("full_pop_count", bus.count, 7);
        check("full_pop_rdy", bus.cpu_rdy, 1);
        tick();
        bus.addr_valid = 1'b0;
        check("ninth_count", bus.count, 8);
        bus.q_accept = 1'b1;
        for (int j = 1; j < 9; j++) begin
            check("order_row", bus.q_row, j + 2);
            check("order_col", bus.q_col, j * 8);
            tick();
        end
        bus.q_accept = 1'b0;
        check("drain_count", bus.count, 0);
        check("drain_valid", bus.q_valid, 0);

        // Steady push+pop at occupancy 3 across pointer wraps
        for (int k = 0; k < 3; k++) push_one(1'b0, (20 + k) << 13);
        check("pp_start_count", bus.count, 3);
        bus.q_accept   = 1'b1;
        bus.addr_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.addr = (23 + c) << 13;
            tick();
            check("pp_count", bus.count, 3);
            check("pp_head_row", bus.q_row, 21 + c);
        end
        bus.addr_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("pp_drain_row", bus.q_row, 40 + k);
            tick();
        end
        bus.q_accept = 1'b0;
        check("pp_end_count", bus.count, 0);

        // Row-hit tracking; bank0 currently holds row 42
        push_one(1'b0, 32'h0000_2000);
        check("hit_miss", bus.q_row_hit, 0);
        pop_one();
        push_one(1'b0, 32'h0000_2040);
        check("hit_col", bus.q_col, 10'h040);
        check("hit_set", bus.q_row_hit, 1);
        bus.pre_all = 1'b1;
        tick();
        bus.pre_all = 1'b0;
        check("hit_preall", bus.q_row_hit, 0);
        bus.pre_all  = 1'b1;
        bus.q_accept = 1'b1;
        tick();
        bus.pre_all  = 1'b0;
        bus.q_accept = 1'b0;
        check("hit_empty", bus.q_row_hit, 0);
        push_one(1'b0, 32'h0000_2080);
        check("hit_after_both", bus.q_row_hit, 1);
        pop_one();

        // Misaligned address
        push_one(1'b0, 32'h0000_0005);
        check("mis_col", bus.q_col, 0);
        check("mis_row", bus.q_row, 0);
        check("mis_align", bus.align_err, 1);
        pop_one();
        push_one(1'b0, 32'h0000_0000);
        check("mis_sticky", bus.align_err, 1);
        pop_one();

        // Reset with 3 entries queued; head hits bank0 row0
        push_one(1'b0, 32'h0000_0000);
        push_one(1'b1, 32'h0000_0008);
        push_one(1'b0, 32'h0000_0010);
        check("mid_count", bus.count, 3);
        check("mid_hit", bus.q_row_hit, 1);
        rst = 1'b1;
        #1;
        check("arst_valid", bus.q_valid, 0);
        check("arst_count", bus.count, 0);
        check("arst_rdy", bus.cpu_rdy, 1);
        check("arst_hit", bus.q_row_hit, 0);
        check("arst_align", bus.align_err, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_valid", bus.q_valid, 0);
        push_one(1'b0, 32'h0000_4000);
        check("post_rst_count", bus.count, 1);
        check("post_rst_row", bus.q_row, 2);
        check("post_rst_hit", bus.q_row_hit, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
